// File: rtl/circ335_pkg.sv
// Shared types and defaults for the circ335 response monitor.
// Holds the FSM state encoding, default timing constants and the expected-output pair.
package circ335_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitMatch = 2'd1,
    StStable    = 2'd2,
    StDone      = 2'd3
  } state_e;

  localparam int unsigned DefMaxWait      = 200;
  localparam int unsigned DefStableCycles = 4;

  typedef struct packed {
    logic d;
    logic e;
  } exp_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with synchronous active-high reset to zero.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/circ335_resp_monitor.sv
// Response monitor for circ335: waits for synchronized D/E to match and stay stable,
// reporting settling latency, glitch count and timeout.
module circ335_resp_monitor
  import circ335_pkg::*;
#(
  parameter int unsigned CW            = 8,
  parameter int unsigned MAX_WAIT      = DefMaxWait,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned GW            = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_exp_d,
  input  logic          i_exp_e,
  input  logic          i_d_in,
  input  logic          i_e_in,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic          o_timeout,
  output logic [CW-1:0] o_latency,
  output logic [GW-1:0] o_glitch_cnt
);

  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LastWait = CW'(MAX_WAIT - 1);
  localparam logic [SW-1:0] LastStab = SW'(STABLE_CYCLES - 1);

  logic [1:0] w_sync;
  exp_t       w_obs;
  logic       w_match;

  sync2 #(
    .W(2)
  ) u_sync (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_d    ({i_d_in, i_e_in}),
    .o_q    (w_sync)
  );

  state_e        r_state,   w_state_nxt;
  exp_t          r_exp,     w_exp_nxt;
  logic [CW-1:0] r_cnt,     w_cnt_nxt;
  logic [SW-1:0] r_stab,    w_stab_nxt;
  logic          r_pass,    w_pass_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_latency, w_latency_nxt;
  logic [GW-1:0] r_glitch,  w_glitch_nxt;

  assign w_obs   = '{d: w_sync[1], e: w_sync[0]};
  assign w_match = (w_obs == r_exp);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_exp     <= '0;
      r_cnt     <= '0;
      r_stab    <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_latency <= '0;
      r_glitch  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp     <= w_exp_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stab    <= w_stab_nxt;
      r_pass    <= w_pass_nxt;
      r_timeout <= w_timeout_nxt;
      r_latency <= w_latency_nxt;
      r_glitch  <= w_glitch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_exp_nxt     = r_exp;
    w_cnt_nxt     = r_cnt;
    w_stab_nxt    = r_stab;
    w_pass_nxt    = r_pass;
    w_timeout_nxt = r_timeout;
    w_latency_nxt = r_latency;
    w_glitch_nxt  = r_glitch;

    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_exp_nxt     = '{d: i_exp_d, e: i_exp_e};
          w_cnt_nxt     = '0;
          w_stab_nxt    = '0;
          w_latency_nxt = '0;
          w_glitch_nxt  = '0;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = StWaitMatch;
        end
      end

      StWaitMatch: begin
        if (w_match) begin
          w_latency_nxt = r_cnt;
          w_stab_nxt    = SW'(1);
          if (STABLE_CYCLES == 1) begin
            w_pass_nxt  = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StStable;
          end
        end else if (r_cnt >= LastWait) begin
          w_timeout_nxt = 1'b1;
          w_pass_nxt    = 1'b0;
          w_state_nxt   = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      StStable: begin
        if (!w_match) begin
          if (r_glitch != '1) begin
            w_glitch_nxt = r_glitch + 1'b1;
          end
          // The wait budget is shared across every WAIT_MATCH visit, so an
          // exhausted budget ends the run here rather than letting cnt grow.
          if (r_cnt >= LastWait) begin
            w_timeout_nxt = 1'b1;
            w_pass_nxt    = 1'b0;
            w_state_nxt   = StDone;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = StWaitMatch;
          end
        end else if (r_stab == LastStab) begin
          w_pass_nxt  = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_stab_nxt = r_stab + 1'b1;
        end
      end

      StDone: begin
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_busy       = (r_state == StWaitMatch) || (r_state == StStable);
  assign o_done       = (r_state == StDone);
  assign o_pass       = r_pass;
  assign o_timeout    = r_timeout;
  assign o_latency    = r_latency;
  assign o_glitch_cnt = r_glitch;

endmodule

// File: tb/tb_circ335_resp_monitor.sv
// Scoreboard bench for circ335_resp_monitor: a run-length reference model predicts each
// transaction's result and done cycle; a monitor compares whenever done is seen.
module tb_circ335_resp_monitor;

  localparam int MW   = 20;
  localparam int SC   = 4;
  localparam int CWB  = 8;
  localparam int GWB  = 4;
  localparam int GMAX = 15;
  localparam int SLEN = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           ed;
  logic           ee;
  logic           din;
  logic           ein;
  logic           o_busy;
  logic           o_done;
  logic           o_pass;
  logic           o_timeout;
  logic [CWB-1:0] o_latency;
  logic [GWB-1:0] o_glitch_cnt;

  circ335_resp_monitor #(
    .CW           (CWB),
    .MAX_WAIT     (MW),
    .STABLE_CYCLES(SC),
    .GW           (GWB)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_exp_d     (ed),
    .i_exp_e     (ee),
    .i_d_in      (din),
    .i_e_in      (ein),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_timeout   (o_timeout),
    .o_latency   (o_latency),
    .o_glitch_cnt(o_glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pass;
    bit tmo;
    int lat;
    int gl;
    int done_cyc;
  } exp_item_t;

  exp_item_t  sbq[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [1:0] seq[SLEN];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: scan synchronized samples; mismatches spend wait budget, a run of SC
  // matches passes. Sample seq[j] is what the FSM sees at edge k+1+j.
  function automatic exp_item_t model(input logic [1:0] xe, input int k);
    exp_item_t r;
    int mm  = 0;
    int run = 0;
    r = '{pass: 1'b0, tmo: 1'b0, lat: 0, gl: 0, done_cyc: -1};
    for (int j = 0; j < SLEN; j++) begin
      if (seq[j] != xe) begin
        if (run > 0) r.gl = (r.gl + 1 > GMAX) ? GMAX : r.gl + 1;
        if (mm >= MW - 1) begin
          r.tmo = 1'b1;
          r.done_cyc = k + 1 + j;
          return r;
        end
        mm++;
        run = 0;
      end else begin
        if (run == 0) r.lat = mm;
        run++;
        if (run == SC) begin
          r.pass = 1'b1;
          r.done_cyc = k + 1 + j;
          return r;
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_item_t it;
        it = sbq.pop_front();
        chk("done_cycle", cyc, it.done_cyc);
        chk("pass", int'(o_pass), int'(it.pass));
        chk("timeout", int'(o_timeout), int'(it.tmo));
        chk("latency", int'(o_latency), it.lat);
        chk("glitch_cnt", int'(o_glitch_cnt), it.gl);
        chk("busy_at_done", int'(o_busy), 0);
      end
    end
  end

  // Starts at a negedge with the DUT idle; returns at a negedge after done.
  task automatic run_txn(input logic [1:0] xe, input bit inj_busy, input bit inj_done);
    exp_item_t it;
    int        j;
    int        budget;
    bit        seen;
    start      = 1'b0;
    {din, ein} = seq[0];
    @(negedge clk);
    {din, ein} = seq[1];
    start      = 1'b1;
    {ed, ee}   = xe;
    it = model(xe, cyc + 1);
    sbq.push_back(it);
    j      = 1;
    seen   = 1'b0;
    budget = 0;
    while (!seen && budget < 200) begin
      @(negedge clk);
      j++;
      budget++;
      start = 1'b0;
      if (o_done) begin
        seen = 1'b1;
      end else begin
        {din, ein} = seq[(j < SLEN) ? j : SLEN - 1];
        if (inj_busy && j == 3) begin
          chk("busy_mid", int'(o_busy), 1);
          start    = 1'b1;
          {ed, ee} = ~xe;
        end
      end
    end
    if (!seen) chk("done_seen", 0, 1);
    if (inj_done) begin
      start    = 1'b1;
      {ed, ee} = ~xe;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", int'(o_busy), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_pass"}, int'(o_pass), 0);
    chk({tag, "_timeout"}, int'(o_timeout), 0);
    chk({tag, "_latency"}, int'(o_latency), 0);
    chk({tag, "_glitch"}, int'(o_glitch_cnt), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit anydone;
    int sp;
    rst   = 1'b1;
    start = 1'b0;
    ed    = 1'b0;
    ee    = 1'b0;
    din   = 1'b0;
    ein   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Immediate match, with an ignored start (complemented expectation) while busy.
    for (int j = 0; j < SLEN; j++) seq[j] = 2'b11;
    run_txn(2'b11, 1'b1, 1'b0);

    // Delayed settle.
    for (int j = 0; j < SLEN; j++) seq[j] = (j < 12) ? 2'b01 : 2'b10;
    run_txn(2'b10, 1'b0, 1'b1);

    // Single glitch in STABLE.
    for (int j = 0; j < SLEN; j++) seq[j] = (j == 2) ? 2'b10 : 2'b11;
    run_txn(2'b11, 1'b0, 1'b0);

    // Timeout.
    for (int j = 0; j < SLEN; j++) seq[j] = 2'b00;
    run_txn(2'b11, 1'b0, 1'b1);

    // Alternating input: glitch counter saturation, then budget exhausted.
    for (int j = 0; j < SLEN; j++) seq[j] = j[0] ? 2'b00 : 2'b11;
    run_txn(2'b11, 1'b0, 1'b0);

    // Reset abort in WAIT_MATCH.
    start      = 1'b0;
    {din, ein} = 2'b00;
    @(negedge clk);
    start    = 1'b1;
    {ed, ee} = 2'b11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", int'(o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst     = 1'b0;
    anydone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_done) anydone = 1'b1;
    end
    chk("no_done_after_abort", int'(anydone), 0);

    // Normal operation after abort.
    for (int j = 0; j < SLEN; j++) seq[j] = (j < 5) ? 2'b00 : 2'b01;
    run_txn(2'b01, 1'b0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      logic [1:0] xe;
      xe = 2'($urandom_range(0, 3));
      sp = $urandom_range(0, 26);
      for (int j = 0; j < SLEN; j++) begin
        if (j < sp) seq[j] = 2'($urandom_range(0, 3));
        else if ($urandom_range(0, 7) == 0) seq[j] = 2'($urandom_range(0, 3));
        else seq[j] = xe;
      end
      run_txn(xe, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circ335_resp_monitor.md
Name: circ335_resp_monitor

Overview:
- Clocked response monitor for the observing end of the circ335 stimulus/response pair (inputs A,B,C; outputs D,E).
- The stimulus side applies a vector and pulses start with the expected outputs. This block waits until the circuit outputs match and stay stable.
- Reports settling latency in clock cycles, counts glitches (match then loss of match) and flags timeouts.
- Used both in lab hardware and as a self-checking monitor in benches.

Parameters:
- CW, 8, width of the latency and wait counters.
- MAX_WAIT, 200, cycles allowed in WAIT_MATCH before timeout (must be ≤ 2^CW-1).
- STABLE_CYCLES, 4, consecutive matching cycles required to declare settled (≥ 1).
- GW, 4, width of the glitch counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request: begin monitoring a new vector.
- exp_d  in  1  expected D, latched on accepted start.
- exp_e  in  1  expected E, latched on accepted start.
- d_in  in  1  circuit output D (asynchronous to clock).
- e_in  in  1  circuit output E (asynchronous to clock).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when monitoring ends (pass or timeout).
- pass  out  1  valid from done until the next accepted start; 1 = settled, 0 = timeout.
- timeout  out  1  sticky until the next accepted start.
- latency  out  CW  WAIT_MATCH cycles counted before the final stable match began.
- glitch_cnt  out  GW  saturating count of match losses during STABLE.

Behaviour:
- Reset: state IDLE. busy, done, pass, timeout = 0; latency = 0; glitch_cnt = 0; synchronizer flops = 0.
- Input sampling: d_in and e_in each pass through a 2-flop synchronizer. All comparisons use the synchronized values ds, es. match = (ds==exp_d_q) && (es==exp_e_q).
- IDLE:
  - start=1: latch exp_d/exp_e; clear cnt, latency, glitch_cnt, pass, timeout; go to WAIT_MATCH.
  - busy is 0 in IDLE.
- WAIT_MATCH:
  - match: latency ← cnt, stab ← 1, go to STABLE.
  - else if cnt == MAX_WAIT-1: timeout ← 1, pass ← 0, go to DONE.
  - else: cnt ← cnt+1.
- STABLE:
  - !match: glitch_cnt ← min(glitch_cnt+1, 2^GW-1); cnt ← cnt+1; go to WAIT_MATCH. The total wait budget spans both visits and does not restart.
  - match and stab == STABLE_CYCLES-1: pass ← 1, go to DONE.
  - match otherwise: stab ← stab+1.
  - STABLE_CYCLES = 1: go straight from WAIT_MATCH to DONE on the first match.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - pass, timeout, latency and glitch_cnt hold until the next accepted start.
- Timing with an immediate match, start accepted at edge k: latency = 0, done high between edges k+STABLE_CYCLES and k+STABLE_CYCLES+1.
- start while busy or in DONE: ignored; the latched expected values do not change.
- exp_d/exp_e are sampled only on an accepted start.
- Reset mid-operation: abort immediately to reset values with no done pulse.
- Counters never wrap: cnt is bounded by MAX_WAIT and glitch_cnt saturates.

Decomposition:
- Shared package circ335_pkg:
  - state enum (IDLE, WAIT_MATCH, STABLE, DONE), 2-bit encoding.
  - default constants for MAX_WAIT and STABLE_CYCLES.
  - expected-output struct {d, e}.
- Sub-module sync2: parameterizable-width 2-flop synchronizer, reset to 0, instantiated once with width 2.
- FSM, counters and result registers stay in circ335_resp_monitor.

Test Plan:
- Immediate match: after reset, hold d_in=1, e_in=1 for ≥3 cycles, start with exp=11 (STABLE_CYCLES=4) → done 4 cycles after the accept edge, pass=1, latency=0, glitch_cnt=0, timeout=0.
- Delayed settle: start exp=10 with inputs 01; switch inputs to 10 after 10 cycles → pass=1, latency=11 (10 cycles plus 2-flop sync delay, minus the cycle entering WAIT_MATCH); busy high throughout.
- Glitch: exp=11 with inputs 11; drop e_in for 1 cycle at stab=2, then restore → glitch_cnt=1, pass=1, latency = WAIT cycles counted before the second match.
- Timeout: MAX_WAIT=20, start exp=11, hold inputs 00 → done exactly 20 cycles after accept, timeout=1, pass=0.
- Ignored start / reset abort: pulse start with exp=00 while busy → latched expectation unchanged. Assert reset mid-WAIT → all outputs 0 the next cycle, no done pulse; the next start works normally.
